// File: rtl/avst_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Avalon-ST transmit port between two packet sources.
// Define TX_ARB_WATCHDOG_EN to compile in the owner-stall watchdog (ABORT/DRAIN recovery).
module avst_tx_arbiter #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               sys_clk,
  input  logic               core_reset_n,
  input  logic [DATA_W-1:0]  s0_data,
  input  logic               s0_valid,
  input  logic               s0_sop,
  input  logic               s0_eop,
  input  logic [EMPTY_W-1:0] s0_empty,
  output logic               s0_ready,
  input  logic [DATA_W-1:0]  s1_data,
  input  logic               s1_valid,
  input  logic               s1_sop,
  input  logic               s1_eop,
  input  logic [EMPTY_W-1:0] s1_empty,
  output logic               s1_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  output logic               m_sop,
  output logic               m_eop,
  output logic [EMPTY_W-1:0] m_empty,
  output logic               m_error,
  input  logic               m_ready,
  output logic [1:0]         grant,
  output logic               err_sop,
  output logic               err_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2
`ifdef TX_ARB_WATCHDOG_EN
    ,
    ABORT  = 3'd3,
    DRAIN  = 3'd4
`endif
  } state_t;

  // One-hot winner among requesters; p names the preferred source.
  function automatic logic [1:0] pick(input logic r0, input logic r1, input logic p);
    logic [1:0] w;
    if (p == 1'b0) begin
      w = r0 ? 2'b01 : (r1 ? 2'b10 : 2'b00);
    end else begin
      w = r1 ? 2'b10 : (r0 ? 2'b01 : 2'b00);
    end
    return w;
  endfunction

  function automatic state_t grant_state(input logic [1:0] w);
    state_t s;
    case (w)
      2'b01:   s = GRANT0;
      2'b10:   s = GRANT1;
      default: s = IDLE;
    endcase
    return s;
  endfunction

  state_t     state;
  logic       ptr;
  logic       own_valid;
  logic       own_eop;
  logic       own_xfer;
  logic       req0;
  logic       req1;
  logic       orphan0;
  logic       orphan1;
  logic       arb_ptr;
  logic [1:0] win;

`ifdef TX_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] wd_cnt;
`else
  // A negative timeout is meaningless, so this folds to a constant 0.
  assign err_timeout = (TIMEOUT < 0);
`endif

  // Owner-side handshake decode and arbitration; on eop the pointer is already flipped to the other source.
  always_comb begin
    own_valid = grant[1] ? s1_valid : s0_valid;
    own_eop   = grant[1] ? s1_eop   : s0_eop;
    own_xfer  = own_valid & m_ready;
    req0      = s0_valid & s0_sop;
    req1      = s1_valid & s1_sop;
    orphan0   = s0_valid & ~s0_sop;
    orphan1   = s1_valid & ~s1_sop;
    arb_ptr   = (state == IDLE) ? ptr : grant[0];
    win       = pick(req0, req1, arb_ptr);
  end

  // Arbiter state machine, round-robin pointer, grant and sticky error flags.
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      grant   <= 2'b00;
      err_sop <= 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          err_sop <= err_sop | orphan0 | orphan1;
          grant   <= win;
          state   <= grant_state(win);
        end
        GRANT0, GRANT1: begin
          if (own_xfer && own_eop) begin
            ptr   <= grant[0];
            grant <= win;
            state <= grant_state(win);
          end
`ifdef TX_ARB_WATCHDOG_EN
          if (own_xfer) begin
            wd_cnt <= '0;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b1;
            state       <= ABORT;
          end else if (!own_valid) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
`ifdef TX_ARB_WATCHDOG_EN
        ABORT: begin
          if (m_ready) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Owner keeps the grant while its stale packet is swallowed up to eop.
          if (own_valid && own_eop) begin
            ptr   <= grant[0];
            grant <= 2'b00;
            state <= IDLE;
          end
        end
`endif
        default: begin
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output mux and source backpressure; readies are forced low while reset is held.
  always_comb begin
    m_data   = '0;
    m_valid  = 1'b0;
    m_sop    = 1'b0;
    m_eop    = 1'b0;
    m_empty  = '0;
    m_error  = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    case (state)
      IDLE: begin
        s0_ready = orphan0;
        s1_ready = orphan1;
      end
      GRANT0: begin
        m_data   = s0_data;
        m_valid  = s0_valid;
        m_sop    = s0_sop;
        m_eop    = s0_eop;
        m_empty  = s0_empty;
        s0_ready = m_ready;
      end
      GRANT1: begin
        m_data   = s1_data;
        m_valid  = s1_valid;
        m_sop    = s1_sop;
        m_eop    = s1_eop;
        m_empty  = s1_empty;
        s1_ready = m_ready;
      end
`ifdef TX_ARB_WATCHDOG_EN
      ABORT: begin
        m_valid = 1'b1;
        m_eop   = 1'b1;
        m_error = 1'b1;
      end
      DRAIN: begin
        s0_ready = grant[0];
        s1_ready = grant[1];
      end
`endif
      default: begin
        m_valid = 1'b0;
      end
    endcase
    s0_ready = s0_ready & core_reset_n;
    s1_ready = s1_ready & core_reset_n;
  end

endmodule

// File: tb/tb_avst_tx_arbiter.sv
// Randomized self-checking bench for avst_tx_arbiter against a packet-queue reference model.
`timescale 1ns/1ps
module tb_avst_tx_arbiter;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int TO = 8;

  logic          sys_clk = 1'b0;
  logic          core_reset_n = 1'b0;
  logic [DW-1:0] s0_data = '0, s1_data = '0, m_data;
  logic          s0_valid = 1'b0, s0_sop = 1'b0, s0_eop = 1'b0, s0_ready;
  logic          s1_valid = 1'b0, s1_sop = 1'b0, s1_eop = 1'b0, s1_ready;
  logic [EW-1:0] s0_empty = '0, s1_empty = '0, m_empty;
  logic          m_valid, m_sop, m_eop, m_error;
  logic          m_ready = 1'b0;
  logic [1:0]    grant;
  logic          err_sop, err_timeout;

  avst_tx_arbiter #(.DATA_W(DW), .EMPTY_W(EW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .core_reset_n(core_reset_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_sop(s0_sop), .s0_eop(s0_eop),
    .s0_empty(s0_empty), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_sop(s1_sop), .s1_eop(s1_eop),
    .s1_empty(s1_empty), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
    .m_empty(m_empty), .m_error(m_error), .m_ready(m_ready),
    .grant(grant), .err_sop(err_sop), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    order[$];
  int    checks = 0;
  int    failures = 0;
  int    owner = -1;
  bit    ptr_m = 1'b0;
  bit    err_sop_m = 1'b0;
  int    vmode = 0;
  int    mrmode = 0;
  bit    mr_tog = 1'b1;
  int    stall0 = 0, stall1 = 0;
  int    delivered = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1, input bit p);
    if (!p) return r0 ? 0 : (r1 ? 1 : -1);
    return r1 ? 1 : (r0 ? 0 : -1);
  endfunction

  task automatic push_pkt(input int src, input int len, input logic [EW-1:0] last_empty);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = DW'($urandom);
      b.sop   = (k == 0);
      b.eop   = (k == len - 1);
      b.empty = b.eop ? last_empty : EW'($urandom);
      if (src == 0) q0.push_back(b); else q1.push_back(b);
      total++;
    end
  endtask

  task automatic push_orphan(input int src);
    beat_t b;
    b.data = DW'($urandom); b.sop = 1'b0; b.eop = 1'b0; b.empty = '0;
    if (src == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  task automatic model_clear();
    owner = -1; ptr_m = 1'b0; err_sop_m = 1'b0;
    q0.delete(); q1.delete(); order.delete();
    stall0 = 0; stall1 = 0; delivered = 0; total = 0;
  endtask

  // One clock: drive at negedge, compare #1 later against the model, then advance the model.
  task automatic cycle();
    beat_t      h0, h1, hn;
    bit         v0, v1, er0, er1, x0, x1, emv, mr;
    logic [1:0] eg;
    @(negedge sys_clk);
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    v0 = (q0.size() > 0) && (vmode == 0 || stall0 >= 3 || $urandom_range(0, 3) != 0);
    v1 = (q1.size() > 0) && (vmode == 0 || stall1 >= 3 || $urandom_range(0, 3) != 0);
    if (mrmode == 0) mr = 1'b1;
    else if (mrmode == 1) mr = ($urandom_range(0, 2) != 0);
    else begin mr = mr_tog; mr_tog = ~mr_tog; end
    s0_valid = v0; s0_data = h0.data; s0_sop = h0.sop; s0_eop = h0.eop; s0_empty = h0.empty;
    s1_valid = v1; s1_data = h1.data; s1_sop = h1.sop; s1_eop = h1.eop; s1_empty = h1.empty;
    m_ready = mr;
    #1;
    er0 = 1'b0; er1 = 1'b0; eg = 2'b00; emv = 1'b0; hn = (owner == 1) ? h1 : h0;
    if (owner < 0) begin
      er0 = v0 && !h0.sop;
      er1 = v1 && !h1.sop;
    end else begin
      eg  = (owner == 1) ? 2'b10 : 2'b01;
      emv = (owner == 1) ? v1 : v0;
      if (owner == 1) er1 = mr; else er0 = mr;
    end
    chk("grant", grant, eg);
    chk("s0_ready", s0_ready, er0);
    chk("s1_ready", s1_ready, er1);
    chk("m_valid", m_valid, emv);
    chk("m_error", m_error, 1'b0);
    chk("err_sop", err_sop, err_sop_m);
    if (emv) begin
      chk("m_data", m_data, hn.data);
      chk("m_sop", m_sop, hn.sop);
      chk("m_eop", m_eop, hn.eop);
      chk("m_empty", m_empty, hn.empty);
    end
    x0 = v0 && er0;
    x1 = v1 && er1;
    if (x0) stall0 = 0; else if (!v0 && q0.size() > 0) stall0++;
    if (x1) stall1 = 0; else if (!v1 && q1.size() > 0) stall1++;
    if (owner < 0) begin
      if (x0) begin err_sop_m = 1'b1; void'(q0.pop_front()); end
      if (x1) begin err_sop_m = 1'b1; void'(q1.pop_front()); end
      owner = pick(v0 && h0.sop, v1 && h1.sop, ptr_m);
    end else if ((owner == 0 && x0) || (owner == 1 && x1)) begin
      if (owner == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      delivered++;
      if (hn.sop) order.push_back(owner);
      if (hn.eop) begin
        ptr_m = (owner == 0);
        owner = pick(v0 && h0.sop, v1 && h1.sop, ptr_m);
      end
    end
    @(posedge sys_clk);
  endtask

  task automatic run_until_empty(input int budget);
    int c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || owner >= 0) && c < budget) begin
      cycle();
      c++;
    end
    chk("drain_budget", q0.size() + q1.size(), 0);
    chk("beats_delivered", delivered, total);
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    core_reset_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s0_ready", s0_ready, 1'b0);
    chk("rst_s1_ready", s1_ready, 1'b0);
    chk("rst_m_error", m_error, 1'b0);
    chk("rst_err_sop", err_sop, 1'b0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    repeat (2) @(negedge sys_clk);
    core_reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single 4-beat packet from s0.
    vmode = 0; mrmode = 0;
    push_pkt(0, 4, 2'd2);
    run_until_empty(50);

    // Contention with alternation: s0, s1, s0.
    do_reset();
    push_pkt(0, 3, 2'd1); push_pkt(0, 3, 2'd0); push_pkt(1, 3, 2'd3);
    run_until_empty(60);
    chk("contend_pkts", order.size(), 3);
    if (order.size() == 3) begin
      chk("contend_first", order[0], 0);
      chk("contend_second", order[1], 1);
      chk("contend_third", order[2], 0);
    end

    // Backpressure on an s1 packet.
    mrmode = 2; mr_tog = 1'b1;
    push_pkt(1, 4, 2'd1);
    run_until_empty(60);
    mrmode = 0;

    // Orphan beat in IDLE, then err_sop must stay sticky.
    push_orphan(0);
    push_pkt(0, 2, 2'd0);
    run_until_empty(40);
    push_pkt(1, 3, 2'd2);
    run_until_empty(40);
    chk("err_sop_sticky", err_sop, 1'b1);

    // Reset during beat 2 of an s1 packet.
    do_reset();
    push_pkt(1, 4, 2'd0);
    repeat (3) cycle();
    @(negedge sys_clk);
    s1_valid = 1'b1; s1_data = q1[0].data; s1_sop = q1[0].sop; s1_eop = q1[0].eop;
    core_reset_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_s1_ready", s1_ready, 1'b0);
    repeat (2) @(negedge sys_clk);
    s1_valid = 1'b0;
    core_reset_n = 1'b1;
    model_clear();
    push_pkt(1, 3, 2'd2); push_pkt(0, 3, 2'd1);
    run_until_empty(60);
    if (order.size() == 2) chk("midrst_rr_first", order[0], 0);
    else chk("midrst_pkts", order.size(), 2);

    // Owner stall: s0 sends sop and then goes quiet.
    do_reset();
    @(negedge sys_clk);
    s0_valid = 1'b1; s0_sop = 1'b1; s0_eop = 1'b0; s0_data = 32'hA5A5_0001; m_ready = 1'b1;
    #1 chk("stall_idle_ready", s0_ready, 1'b0);
    @(negedge sys_clk);
    #1 chk("stall_sop_out", m_valid & m_sop, 1'b1);
    for (int i = 0; i < TO; i++) begin
      @(negedge sys_clk);
      s0_valid = 1'b0;
      #1;
      chk("stall_grant", grant, 2'b01);
      chk("stall_m_valid", m_valid, 1'b0);
    end
`ifdef TX_ARB_WATCHDOG_EN
    @(negedge sys_clk);
    m_ready = 1'b0;
    #1;
    chk("abort_valid", m_valid, 1'b1);
    chk("abort_eop", m_eop, 1'b1);
    chk("abort_sop", m_sop, 1'b0);
    chk("abort_error", m_error, 1'b1);
    chk("abort_data", m_data, 32'h0);
    chk("abort_empty", m_empty, 2'd0);
    chk("abort_s0_ready", s0_ready, 1'b0);
    chk("abort_err_timeout", err_timeout, 1'b1);
    @(negedge sys_clk);
    m_ready = 1'b1;
    #1 chk("abort_hold", m_error, 1'b1);
    @(negedge sys_clk);
    s0_valid = 1'b1; s0_sop = 1'b0; s0_eop = 1'b0;
    #1;
    chk("drain_ready", s0_ready, 1'b1);
    chk("drain_m_valid", m_valid, 1'b0);
    @(negedge sys_clk);
    s0_eop = 1'b1;
    #1;
    chk("drain_eop_ready", s0_ready, 1'b1);
    chk("drain_eop_m_valid", m_valid, 1'b0);
`else
    repeat (12) begin
      @(negedge sys_clk);
      #1 chk("hold_grant", grant, 2'b01);
    end
    chk("no_wd_err_timeout", err_timeout, 1'b0);
    @(negedge sys_clk);
    s0_valid = 1'b1; s0_sop = 1'b0; s0_eop = 1'b1;
    #1 chk("late_eop_out", m_valid & m_eop, 1'b1);
`endif
    @(negedge sys_clk);
    s0_valid = 1'b0; s0_eop = 1'b0;
    #1 chk("stall_back_idle", grant, 2'b00);
    model_clear();
    ptr_m = 1'b1;
    push_pkt(1, 3, 2'd1);
    run_until_empty(40);
    if (order.size() == 1) chk("after_stall_s1", order[0], 1);
    else chk("after_stall_pkts", order.size(), 1);

    // Randomized traffic with random valid gaps and MAC backpressure.
    do_reset();
    vmode = 1; mrmode = 1;
    for (int k = 0; k < 40; k++) begin
      push_pkt(k % 2, $urandom_range(2, 5), EW'($urandom));
    end
    run_until_empty(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avst_tx_arbiter.md
# avst_tx_arbiter

Packet-level arbiter that shares the TSE 0 Avalon-ST transmit port between two packet sources: source 0 is the forwarding path out of the internal processing core, and source 1 is a locally generated or injected stream. Packets are never interleaved. The arbiter alternates round-robin at packet boundaries, and its output connects directly to the MAC transmit interface.

## Interface
- DATA_W, default 32: beat data width.
- EMPTY_W, default 2: empty-field width.
- TIMEOUT, default 1024: source-stall cycles before an abort; only used when the watchdog is compiled in.
- sys_clk  in  1  system clock; every flop sits on its rising edge.
- core_reset_n  in  1  reset, asynchronous assert, active-low.
- s0_data, s1_data  in  DATA_W  source beat data.
- s0_valid, s1_valid  in  1  source beat valid.
- s0_sop / s0_eop, s1_sop / s1_eop  in  1  source start- and end-of-packet flags.
- s0_empty, s1_empty  in  EMPTY_W  source empty bytes; meaningful only on eop.
- s0_ready, s1_ready  out  1  source backpressure.
- m_data  out  DATA_W  output beat data to the MAC.
- m_valid, m_sop, m_eop  out  1  output valid and packet flags.
- m_empty  out  EMPTY_W  output empty bytes.
- m_error  out  1  output error flag.
- m_ready  in  1  MAC backpressure.
- grant  out  2  one-hot current owner; 00 means idle.
- err_sop  out  1  sticky flag: a beat without sop arrived while idle.
- err_timeout  out  1  sticky flag: a watchdog abort occurred. Tied to 0 when the watchdog is compiled out.

## Operation
- States: IDLE, GRANT0, GRANT1. With the watchdog compiled in, add ABORT and DRAIN.
- Handshake: readyLatency 0. A transfer occurs when valid and ready are both high on a rising edge.
- GRANTn datapath is combinational:
  - m_* = sn_*.
  - sn_ready = m_ready.
  - The other source's ready = 0.
- IDLE:
  - m_valid = 0.
  - A source with valid=1 and sop=0 gets ready=1; the beat is discarded and err_sop is set.
  - A source with valid=1 and sop=1 is a requester and gets ready=0.
  - If there are requesters, the registered next state is GRANTn. The winner is the requester holding the round-robin pointer's priority.
- Round-robin pointer:
  - The pointer names the preferred source and resets to 0.
  - When a packet from source n completes, the pointer moves to the other source.
- End of packet in GRANTn (eop transfer):
  - Next-state logic re-arbitrates in the same cycle, using current valid&sop of both sources with the updated pointer.
  - The next state is GRANTm, or IDLE if no source is requesting.
- m_error = 0 except during ABORT.
- Reset mid-packet:
  - All state clears immediately.
  - The partial packet is not terminated; the MAC's own reset handling covers it.

## Timing
- Reset values:
  - state = IDLE, pointer = 0, grant = 00.
  - m_valid = 0, s0_ready = s1_ready = 0, m_error = 0.
  - err_sop = err_timeout = 0, watchdog count = 0.
- Arbitration latency: 1 cycle. A sop beat presented in IDLE at cycle t appears on m_* at cycle t+1.
- Back-to-back packets have zero bubble: if a request is pending when eop transfers at cycle t, the new owner's sop may transfer at t+1.
- Data path latency in GRANTn: 0 cycles, no registers.
- Simultaneous sop on both sources in IDLE: the pointer decides. The loser holds its data with ready=0.

## Configuration
- TX_ARB_WATCHDOG_EN defined:
  - In GRANTn, a counter increments on each cycle with sn_valid=0 and clears on every transfer.
  - When the count reaches TIMEOUT-1, the next state is ABORT.
  - ABORT drives m_valid=1, m_sop=0, m_eop=1, m_error=1, m_empty=0, m_data=0, with both s_ready=0. It holds until m_ready, then moves to DRAIN.
  - On entering ABORT, err_timeout is set.
  - DRAIN holds sn_ready=1 and m_valid=0, discarding beats until sn eop transfers. It then goes to IDLE with the pointer advanced.
- TX_ARB_WATCHDOG_EN undefined:
  - No counter, and no ABORT or DRAIN states.
  - A stalled owner holds the grant indefinitely.
  - err_timeout = 0.

## Test plan
- Single packet: s0 sends 4 beats (sop at beat 0, eop at beat 3, empty=2) with m_ready=1. Output: m_* is identical 1 cycle after the first request; grant=01 for 4 cycles, then 00.
- Contention: s0 and s1 raise sop in the same cycle, both with 3-beat packets. Output: s0's packet, then s1's packet with no idle cycle; a third s0 packet follows s1, confirming alternation.
- Backpressure: m_ready toggles 1,0,1,0 during an s1 packet. Output: s1_ready mirrors m_ready; data is unchanged while stalled; no beats are lost or duplicated.
- Orphan beat: s0_valid=1 with sop=0 in IDLE. Output: s0_ready=1, the beat is dropped, err_sop=1 and stays 1 until reset.
- Watchdog (macro on, TIMEOUT=8): s0 sends sop, then valid=0 for 8 cycles. Output: an m_eop/m_error beat, then err_timeout=1; s0 then sends 2 beats ending in eop, which are discarded with m_valid=0; a following s1 packet is granted.
- Reset mid-packet: assert core_reset_n=0 during beat 2 of an s1 packet. Output: grant=00, m_valid=0 and s1_ready=0 in the same cycle; after release, the next sop is arbitrated normally.
